// File: rtl/except_ctrl.sv
// MEM-stage exception arbiter feeding the CP0 register block: interrupt synchroniser,
// prioritised exception encoding with WB mtc0 bypass, and registered flush/redirect.
module except_ctrl #(
  parameter logic [31:0] EXC_VECTOR      = 32'hBFC00380,
  parameter logic [4:0]  CP0_STATUS_ADDR = 5'd12,
  parameter logic [4:0]  CP0_CAUSE_ADDR  = 5'd13,
  parameter logic [4:0]  CP0_EPC_ADDR    = 5'd14
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [5:0]  int_raw_i,
  output logic [5:0]  int_sync_o,
  input  logic        mem_valid_i,
  input  logic        mem_stall_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic [7:0]  mem_excflags_i,
  input  logic [31:0] mem_data_addr_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  localparam logic [0:0] NORMAL = 1'b0;
  localparam logic [0:0] FLUSH  = 1'b1;

  logic [0:0]  state;
  logic [5:0]  int_meta;
  logic [31:0] status_eff;
  logic [31:0] cause_eff;
  logic [31:0] epc_eff;
  logic        int_pending;
  logic        take;
  logic        unused_ok;

  // Cause is only software-writable in IP[1:0]; hardware IP bits stay from CP0.
  always_comb begin
    status_eff = cp0_status_i;
    cause_eff  = cp0_cause_i;
    epc_eff    = cp0_epc_i;
    if (wb_cp0_we_i && (wb_cp0_waddr_i == CP0_STATUS_ADDR)) status_eff = wb_cp0_data_i;
    if (wb_cp0_we_i && (wb_cp0_waddr_i == CP0_CAUSE_ADDR))  cause_eff[9:8] = wb_cp0_data_i[9:8];
    if (wb_cp0_we_i && (wb_cp0_waddr_i == CP0_EPC_ADDR))    epc_eff = wb_cp0_data_i;
  end

  assign unused_ok = ^{status_eff[31:16], status_eff[7:2], cause_eff[31:16], cause_eff[7:0]};

  assign int_pending = status_eff[0] && !status_eff[1] &&
                       (|(cause_eff[15:8] & status_eff[15:8]));

  assign take = resetn && (state == NORMAL) && mem_valid_i && !mem_stall_i;

  always_comb begin
    excepttype_o = '0;
    bad_addr_o   = '0;
    if (take) begin
      if (int_pending)            excepttype_o = 32'h01;
      else if (mem_excflags_i[0]) begin
        excepttype_o = 32'h04;
        bad_addr_o   = mem_pc_i;
      end
      else if (mem_excflags_i[1]) excepttype_o = 32'h0a;
      else if (mem_excflags_i[2]) excepttype_o = 32'h0c;
      else if (mem_excflags_i[3]) excepttype_o = 32'h08;
      else if (mem_excflags_i[4]) excepttype_o = 32'h09;
      else if (mem_excflags_i[5]) excepttype_o = 32'h0e;
      else if (mem_excflags_i[6]) begin
        excepttype_o = 32'h04;
        bad_addr_o   = mem_data_addr_i;
      end
      else if (mem_excflags_i[7]) begin
        excepttype_o = 32'h05;
        bad_addr_o   = mem_data_addr_i;
      end
    end
  end

  assign current_inst_addr_o = mem_pc_i;
  assign is_in_delayslot_o   = mem_in_delayslot_i;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      int_meta   <= '0;
      int_sync_o <= '0;
      state      <= NORMAL;
      flush_o    <= 1'b0;
      new_pc_o   <= '0;
    end else begin
      int_meta   <= int_raw_i;
      int_sync_o <= int_meta;
      case (state)
        NORMAL: begin
          if (excepttype_o != '0) begin
            state    <= FLUSH;
            flush_o  <= 1'b1;
            new_pc_o <= (excepttype_o == 32'h0e) ? epc_eff : EXC_VECTOR;
          end
        end
        FLUSH: begin
          state   <= NORMAL;
          flush_o <= 1'b0;
        end
        default: begin
          state   <= NORMAL;
          flush_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/except_ctrl.md
Name: except_ctrl

Overview:
- MEM-stage exception arbiter; sits directly upstream of the CP0 register block.
- Samples and synchronises external interrupt lines, prioritises per-instruction exception flags and produces the exception code, EPC source PC, delay-slot flag and bad address the CP0 block consumes each cycle.
- Generates the registered pipeline flush pulse and redirect PC (exception vector, or EPC for eret).
- Bypasses a same-cycle WB-stage mtc0 to Status/Cause/EPC so decisions use up-to-date CP0 state.

Parameters:
- EXC_VECTOR, 32'hBFC00380, redirect target for all non-eret exceptions.
- CP0_STATUS_ADDR, 5'd12, Status register number for bypass match.
- CP0_CAUSE_ADDR, 5'd13, Cause register number for bypass match.
- CP0_EPC_ADDR, 5'd14, EPC register number for bypass match.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- int_raw_i  in  6  asynchronous hardware interrupt lines
- int_sync_o  out  6  synchronised interrupts, drive CP0 int_i
- mem_valid_i  in  1  MEM stage holds a real instruction
- mem_stall_i  in  1  MEM stage stalled (e.g. data SRAM wait)
- mem_pc_i  in  32  PC of MEM instruction
- mem_in_delayslot_i  in  1  MEM instruction is in a delay slot
- mem_excflags_i  in  8  [0]fetch AdEL [1]RI [2]Ov [3]syscall [4]break [5]eret [6]load AdEL [7]store AdES
- mem_data_addr_i  in  32  load/store effective address
- cp0_status_i  in  32  CP0 Status
- cp0_cause_i  in  32  CP0 Cause
- cp0_epc_i  in  32  CP0 EPC
- wb_cp0_we_i  in  1  WB-stage mtc0 write enable
- wb_cp0_waddr_i  in  5  WB mtc0 register number
- wb_cp0_data_i  in  32  WB mtc0 data
- excepttype_o  out  32  exception code to CP0 (0 = none)
- current_inst_addr_o  out  32  PC to CP0
- is_in_delayslot_o  out  1  delay-slot flag to CP0
- bad_addr_o  out  32  BadVAddr to CP0
- flush_o  out  1  one-cycle pipeline flush pulse (registered)
- new_pc_o  out  32  redirect PC, valid while flush_o=1 (registered)

Behaviour:
- Reset: resetn synchronous, active-low. Both sync flops and int_sync_o 0, state NORMAL, flush_o 0, new_pc_o 0. Combinational outputs: excepttype_o 0 while resetn=0.
- Interrupt sync: two flops per bit. int_sync_o is the second flop; latency 2 cycles from int_raw_i.
- Bypass, per register: effective value = wb_cp0_data_i when wb_cp0_we_i and wb_cp0_waddr_i match; otherwise the cp0_*_i value. Cause bypass replaces only bits [9:8]; bits [15:10] always come from cp0_cause_i.
- Interrupt pending: status_eff[0]=1, status_eff[1]=0 and |(cause_eff[15:8] & status_eff[15:8]).
- Take condition: state NORMAL, mem_valid_i=1, mem_stall_i=0. When the condition is false, excepttype_o=0.
- Fixed priority, highest first, with excepttype_o code:
  - interrupt 0x01
  - fetch AdEL 0x04
  - RI 0x0a
  - Ov 0x0c
  - syscall 0x08
  - break 0x09
  - eret 0x0e
  - load AdEL 0x04
  - store AdES 0x05
- bad_addr_o: mem_pc_i for fetch AdEL; mem_data_addr_i for load AdEL and store AdES; 0 otherwise.
- current_inst_addr_o = mem_pc_i and is_in_delayslot_o = mem_in_delayslot_i, always (combinational).
- FSM states:
  - NORMAL: a nonzero excepttype_o moves to FLUSH at the next edge. On that edge flush_o<=1. new_pc_o <= epc_eff for eret, else EXC_VECTOR.
  - FLUSH: excepttype_o is forced to 0, which suppresses re-raise by the flushed instruction. flush_o<=0 and the FSM returns to NORMAL at the next edge.
- flush_o is high exactly one cycle per taken exception. Back-to-back exceptions are at least 2 cycles apart.
- Stall: mem_stall_i=1 holds off the exception (code 0). It is taken on the first unstalled cycle.
- Reset mid-FLUSH: state forced to NORMAL and flush_o to 0 at the reset edge.

Test Plan:
- No-op: reset, then mem_valid_i=1 with flags 0 -> excepttype_o=0 and flush_o never rises.
- Interrupt sync: int_raw_i=6'b000001 at cycle 0 -> int_sync_o=1 at cycle 2. Then with cause_i[10]=1, status_i=32'h0000_0401, mem_pc_i=32'hBFC0_1000 -> excepttype_o=0x01 and addr 0xBFC01000. Next cycle flush_o=1, new_pc_o=0xBFC00380.
- Priority: flags 8'b1000_0110 (RI+Ov+AdES) -> excepttype_o=0x0a and bad_addr_o=0.
- Store AdES: flags[7]=1, mem_data_addr_i=32'h8000_0003, mem_in_delayslot_i=1 -> code 0x05, bad_addr_o=0x80000003, is_in_delayslot_o=1.
- eret with bypass: cp0_epc_i=0x100, WB mtc0 to reg 14 with data 0xBFC0_2000, flags[5]=1 -> code 0x0e. Next cycle new_pc_o=0xBFC02000 with flush_o=1.
- Stall and FLUSH suppression: syscall flag with mem_stall_i=1 for 3 cycles -> code 0. Release -> code 0x08 once. During the FLUSH cycle, flag still high -> code 0 and a single flush pulse. Reset asserted in FLUSH -> flush_o=0 next cycle.
